trng_entropy_pool: RTL and testbench
====================================

Name: trng_entropy_pool

Overview:
Parametrised ring-oscillator TRNG front end. Instantiates NUM_OSC ring_osc instances with distinct prime stage counts, synchronises their outputs and XOR-reduces them into one entropy bit. The bit is sampled on a software trigger or a programmable free-running tick, packed into WORD_W-bit words and queued in a small FIFO with a valid/ready handshake. A repetition-count health test gates output. The block sits between the oscillator fabric and the AXI-lite register/DMA layer of the HSM.

Parameters:
NUM_OSC, 4, number of ring oscillators (1..8); stage counts taken from package table.
WORD_W, 32, bits per output word (8..64).
FIFO_DEPTH, 4, output word FIFO depth (power of 2, >=2).
DIV_W, 16, width of continuous-mode sample divider.
RCT_CUTOFF, 32, consecutive identical raw bits that trip the health test.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
enable  in  1  oscillator enable; ticks suppressed when low
mode  in  1  0 = triggered (sample_trig rising edge), 1 = continuous (divider)
sample_trig  in  1  single-sample trigger, edge-detected internally
clk_div  in  DIV_W  continuous mode: one tick every max(clk_div,1) cycles
clear  in  1  synchronous flush of accumulator, FIFO, counters, flags
raw_osc  out  NUM_OSC  unsynchronised oscillator outputs (debug)
word_data  out  WORD_W  FIFO head word
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts word_data when word_valid & word_ready
fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently queued
bit_count  out  32  accepted entropy bits since reset/clear, wraps at 2^32
overflow  out  1  sticky: completed word dropped because FIFO full
health_fail  out  1  sticky: repetition-count test tripped
osc_running  out  1  equals enable

Behaviour:
- Reset: all outputs 0, FIFO empty, divider 0, accumulator 0, edge-detect register 0. Reset mid-word discards the partial word.
- Sync: raw_osc through 2-flop synchroniser; entropy bit = XOR of second-stage flops.
- Tick, mode 0: sample_trig & ~sample_trig_d, gated by enable.
- Tick, mode 1: divider counts 0..max(clk_div,1)-1 while enable; tick on the terminal count, then reset to 0. clk_div=0 or 1 gives a tick every cycle. Divider held at 0 when enable=0 or mode=0. A mode change takes effect the next cycle.
- On tick: the sampled bit is "accepted" (see optional feature). Accepted bit shifts into LSB, accumulator <= {acc[WORD_W-2:0], bit}; bit_count += 1.
- Word complete: on the WORD_W-th accepted bit, the full word (including the new bit) is pushed the next cycle. word_valid is high 1 cycle after the completing tick if the FIFO was empty. The accumulator count restarts at 0; accumulator contents are not zeroed.
- Push if FIFO not full, or full with a pop in the same cycle. Otherwise drop the word and set overflow.
- While health_fail=1, completed words are discarded silently. overflow is not set for these drops.
- Health RCT: runs on every tick's raw bit, before debiasing. The run counter counts identical consecutive values. Run length reaching RCT_CUTOFF sets health_fail. Only clear or reset releases it.
- FIFO: first-word fall-through; word_data is stable while word_valid & ~word_ready. Simultaneous push and pop leaves level unchanged.
- clear: highest priority over tick/push/pop. Empties FIFO; zeroes accumulator, bit/word counters, RCT state, overflow, health_fail. Does not touch synchronisers.
- enable low: no ticks; partial word retained; FIFO still drains.

Optional Feature:
TRNG_VN_DEBIAS_EN
- Defined: von Neumann corrector on ticked bits. Bits are taken in pairs; 01->0 accepted, 10->1 accepted, 00/11 discarded. Only accepted bits increment bit_count. Pair state is cleared by clear/reset.
- Undefined: every tick's bit is accepted.

Decomposition:
- Package trng_pkg: OSC_STAGES constant array {13,17,19,23,29,31,37,41}; function clog2-based level width; localparam MAX_OSC=8.
- Sub-module trng_word_fifo: parametrised WORD_W x FIFO_DEPTH FWFT FIFO with push/pop/full/level/flush.
- ring_osc is instantiated as-is through a generate loop.

Test Plan:
- Debias off, force raw entropy bit pattern 1,0 repeating; mode 1, clk_div=1, WORD_W=32 -> first word 0xAAAAAAAA, word_valid 1 cycle after the 32nd tick, bit_count=32.
- mode 0, hold sample_trig high 10 cycles -> exactly 1 tick, bit_count=1; mode 1, clk_div=4 -> ticks every 4 cycles.
- word_ready=0, generate FIFO_DEPTH+1 words -> fifo_level=4, overflow=1, head word unchanged; then pop all 4 -> order preserved.
- Force raw bit stuck at 0 for 32 ticks -> health_fail=1 at the 32nd tick, further words discarded; clear -> health_fail=0, level=0, bit_count=0.
- With TRNG_VN_DEBIAS_EN, raw pairs 01,10,00,11,10 -> accepted bits 0,1,1, bit_count=3.
- Assert rst_n low mid-word with 2 words queued -> all outputs 0 immediately; after release, the first word needs the full 32 new accepted bits.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants and helpers for the ring-oscillator TRNG front end.
package trng_pkg;
  localparam int MAX_OSC = 8;

  // Prime stage counts keep the oscillators from phase-locking to one another.
  localparam logic [MAX_OSC-1:0][7:0] OSC_STAGES =
    {8'd41, 8'd37, 8'd31, 8'd29, 8'd23, 8'd19, 8'd17, 8'd13};

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ring_osc.sv
// Clocked behavioural stand-in for the hard ring-oscillator cell: toggles every
// STAGES cycles while enabled; the silicon build binds the real oscillator macro.
module ring_osc #(
  parameter int STAGES = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic osc_out
);
  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      osc_out <= 1'b0;
    end else if (enable) begin
      if (cnt_reg == 8'(STAGES - 1)) begin
        cnt_reg <= '0;
        osc_out <= ~osc_out;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end
endmodule

// File: rtl/trng_word_fifo.sv
// First-word-fall-through word FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. flush has priority over push/pop.
module trng_word_fifo import trng_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WORD_W-1:0]         push_data,
  input  logic                      pop,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = level_w(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              do_push, do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/trng_entropy_pool.sv
// TRNG entropy pool: ring oscillators -> 2FF sync -> XOR -> sampled bits -> words -> FIFO.
// Build option TRNG_VN_DEBIAS_EN inserts a von Neumann corrector before the word packer.
module trng_entropy_pool import trng_pkg::*; #(
  parameter int NUM_OSC    = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           mode,
  input  logic                           sample_trig,
  input  logic [DIV_W-1:0]               clk_div,
  input  logic                           clear,
  output logic [NUM_OSC-1:0]             raw_osc,
  output logic [WORD_W-1:0]              word_data,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic [31:0]                    bit_count,
  output logic                           overflow,
  output logic                           health_fail,
  output logic                           osc_running
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OSC; gi++) begin : g_osc
      ring_osc #(.STAGES(int'(OSC_STAGES[gi]))) u_osc (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .osc_out (raw_osc[gi])
      );
    end
  endgenerate

  logic [NUM_OSC-1:0] sync1_reg, sync2_reg;
  logic               trig_d_reg;
  logic               raw_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      trig_d_reg <= 1'b0;
    end else begin
      sync1_reg  <= raw_osc;
      sync2_reg  <= sync1_reg;
      trig_d_reg <= sample_trig;
    end
  end

  assign raw_bit = ^sync2_reg;

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next, div_term;
  logic             div_tick, tick;

  assign div_term = (clk_div > DIV_W'(1)) ? clk_div - DIV_W'(1) : '0;

  // >= rather than == so shrinking clk_div mid-count does not wait for a wrap.
  always_comb begin
    div_tick     = 1'b0;
    div_cnt_next = '0;
    if (enable && mode) begin
      if (div_cnt_reg >= div_term) div_tick = 1'b1;
      else                         div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  assign tick = enable & (mode ? div_tick : (sample_trig & ~trig_d_reg));

  logic accept, accept_bit;

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_have_reg, pair_first_reg;

  // Pair (first, second): 01 -> 0, 10 -> 1, equal pairs are dropped.
  assign accept     = tick & pair_have_reg & (pair_first_reg != raw_bit);
  assign accept_bit = pair_first_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_have_reg  <= 1'b0;
      pair_first_reg <= 1'b0;
    end else if (clear) begin
      pair_have_reg  <= 1'b0;
      pair_first_reg <= 1'b0;
    end else if (tick) begin
      pair_have_reg <= ~pair_have_reg;
      if (!pair_have_reg) pair_first_reg <= raw_bit;
    end
  end
`else
  assign accept     = tick;
  assign accept_bit = raw_bit;
`endif

  logic [WORD_W-1:0] acc_reg;
  logic [CNT_W-1:0]  acc_cnt_reg;
  logic              word_done_reg;
  logic [RCT_W-1:0]  rct_cnt_reg, rct_next;
  logic              rct_last_reg;
  logic [31:0]       bit_count_reg;
  logic              overflow_reg, health_fail_reg;
  logic              push, pop, fifo_full, fifo_empty;

  assign pop  = word_valid & word_ready;
  assign push = word_done_reg & ~health_fail_reg;

  // Run length of the raw (pre-debias) bit, saturating at the cutoff.
  assign rct_next = (rct_cnt_reg != '0 && raw_bit == rct_last_reg)
                  ? ((rct_cnt_reg == RCT_W'(RCT_CUTOFF)) ? rct_cnt_reg : rct_cnt_reg + RCT_W'(1))
                  : RCT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      acc_reg         <= '0;
      acc_cnt_reg     <= '0;
      word_done_reg   <= 1'b0;
      rct_cnt_reg     <= '0;
      rct_last_reg    <= 1'b0;
      bit_count_reg   <= '0;
      overflow_reg    <= 1'b0;
      health_fail_reg <= 1'b0;
    end else if (clear) begin
      div_cnt_reg     <= '0;
      acc_reg         <= '0;
      acc_cnt_reg     <= '0;
      word_done_reg   <= 1'b0;
      rct_cnt_reg     <= '0;
      rct_last_reg    <= 1'b0;
      bit_count_reg   <= '0;
      overflow_reg    <= 1'b0;
      health_fail_reg <= 1'b0;
    end else begin
      div_cnt_reg   <= div_cnt_next;
      word_done_reg <= 1'b0;
      if (tick) begin
        rct_cnt_reg  <= rct_next;
        rct_last_reg <= raw_bit;
        if (rct_next == RCT_W'(RCT_CUTOFF)) health_fail_reg <= 1'b1;
      end
      if (accept) begin
        acc_reg       <= {acc_reg[WORD_W-2:0], accept_bit};
        bit_count_reg <= bit_count_reg + 32'd1;
        if (acc_cnt_reg == CNT_W'(WORD_W - 1)) begin
          acc_cnt_reg   <= '0;
          word_done_reg <= 1'b1;
        end else begin
          acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
        end
      end
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  // acc_reg already holds the completed word during the push cycle.
  trng_word_fifo #(.WORD_W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (push),
    .push_data (acc_reg),
    .pop       (pop),
    .rd_data   (word_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign word_valid  = ~fifo_empty;
  assign bit_count   = bit_count_reg;
  assign overflow    = overflow_reg;
  assign health_fail = health_fail_reg;
  assign osc_running = enable;
endmodule

// File: tb/tb_trng_entropy_pool.sv
// Directed self-checking bench for trng_entropy_pool; the XORed entropy bit is
// forced so every accepted bit and packed word is known in advance.
module tb_trng_entropy_pool;
  localparam int NUM_OSC    = 4;
  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int RCT_CUTOFF = 32;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              mode = 1'b0;
  logic              sample_trig = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              clear = 1'b0;
  logic              word_ready = 1'b0;
  logic [NUM_OSC-1:0] raw_osc;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic [31:0]       bit_count;
  logic              overflow, health_fail, osc_running;

  int   checks = 0;
  int   failures = 0;
  logic force_bit = 1'b0;
  logic [WORD_W-1:0] words [5] = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5C3C3,
                                   32'h0F1E2D3C, 32'h55AA33CC};

  trng_entropy_pool #(
    .NUM_OSC(NUM_OSC), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W(DIV_W), .RCT_CUTOFF(RCT_CUTOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .sample_trig(sample_trig), .clk_div(clk_div), .clear(clear),
    .raw_osc(raw_osc), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .fifo_level(fifo_level), .bit_count(bit_count),
    .overflow(overflow), .health_fail(health_fail), .osc_running(osc_running)
  );

  always #5 clk = ~clk;

  task automatic tick_bit(input logic b);
    @(negedge clk); force_bit = b; sample_trig = 1'b1;
    @(negedge clk); sample_trig = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) tick_bit(w[i]);
  endtask

  task automatic do_clear;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", word_valid); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL rst_bit_count got=%0d exp=0", bit_count); end
    checks++; if (word_data !== 32'd0) begin failures++; $display("FAIL rst_word_data got=%h exp=0", word_data); end
    checks++; if ({overflow, health_fail} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {overflow, health_fail}); end
    checks++; if (raw_osc !== 4'd0) begin failures++; $display("FAIL rst_raw_osc got=%b exp=0", raw_osc); end
    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (osc_running !== 1'b1) begin failures++; $display("FAIL osc_running got=%b exp=1", osc_running); end
    checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL idle_bit_count got=%0d exp=0", bit_count); end
    $display("test_reset done");
  endtask

  task automatic test_continuous_word;
    do_clear();
    @(negedge clk); clk_div = 16'd1; mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      force_bit = ((i % 2) == 0);
      @(negedge clk);
    end
    mode = 1'b0;
    checks++; if (bit_count !== 32'd32) begin failures++; $display("FAIL cont_bit_count got=%0d exp=32", bit_count); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL cont_valid_early got=%b exp=0", word_valid); end
    @(negedge clk);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL cont_valid got=%b exp=1", word_valid); end
    checks++; if (word_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL cont_word got=%h exp=aaaaaaaa", word_data); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL cont_level got=%0d exp=1", fifo_level); end
    $display("test_continuous_word word=%h", word_data);
  endtask

  task automatic test_trigger_and_divider;
    do_clear();
    @(negedge clk); force_bit = 1'b1; sample_trig = 1'b1;
    repeat (10) @(negedge clk);
    sample_trig = 1'b0;
    @(negedge clk);
    checks++; if (bit_count !== 32'd1) begin failures++; $display("FAIL trig_bit_count got=%0d exp=1", bit_count); end
    do_clear();
    clk_div = 16'd4; mode = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++; if (bit_count !== 32'(e / 4)) begin failures++; $display("FAIL div4_edge%0d got=%0d exp=%0d", e, bit_count, e / 4); end
    end
    mode = 1'b0;
    $display("test_trigger_and_divider bit_count=%0d", bit_count);
  endtask

  task automatic test_overflow;
    do_clear();
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(words[k]);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level4 got=%0d exp=4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    send_word(words[4]);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (word_data !== words[k]) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", k, word_data, words[k]); end
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      checks++; if (fifo_level !== 3'(3 - k)) begin failures++; $display("FAIL ovf_level_pop%0d got=%0d exp=%0d", k, fifo_level, 3 - k); end
    end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", word_valid); end
    $display("test_overflow popped 4 words");
  endtask

  task automatic test_health;
    do_clear();
    for (int i = 0; i < 31; i++) tick_bit(1'b0);
    checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL rct_31 got=%b exp=0", health_fail); end
    tick_bit(1'b0);
    checks++; if (health_fail !== 1'b1) begin failures++; $display("FAIL rct_32 got=%b exp=1", health_fail); end
    repeat (2) @(negedge clk);
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rct_drop1 got=%0d exp=0", fifo_level); end
    send_word(32'hAAAAAAAA);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rct_drop2 got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rct_no_ovf got=%b exp=0", overflow); end
    checks++; if (bit_count !== 32'd64) begin failures++; $display("FAIL rct_bit_count got=%0d exp=64", bit_count); end
    do_clear();
    checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL rct_clear got=%b exp=0", health_fail); end
    checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL clr_bit_count got=%0d exp=0", bit_count); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL clr_level got=%0d exp=0", fifo_level); end
    $display("test_health cleared");
  endtask

  task automatic test_accept;
    logic [9:0]        pairs;
    logic [WORD_W-1:0] exp_word;
    do_clear();
    pairs = 10'b0110001110;
    for (int i = 9; i >= 0; i--) tick_bit(pairs[i]);
`ifdef TRNG_VN_DEBIAS_EN
    checks++; if (bit_count !== 32'd3) begin failures++; $display("FAIL vn_bit_count got=%0d exp=3", bit_count); end
    for (int i = 0; i < 29; i++) begin tick_bit(1'b1); tick_bit(1'b0); end
    exp_word = 32'h7FFFFFFF;
`else
    checks++; if (bit_count !== 32'd10) begin failures++; $display("FAIL raw_bit_count got=%0d exp=10", bit_count); end
    for (int i = 0; i < 11; i++) begin tick_bit(1'b1); tick_bit(1'b0); end
    exp_word = 32'h63AAAAAA;
`endif
    @(negedge clk);
    checks++; if (bit_count !== 32'd32) begin failures++; $display("FAIL acc_bit_count got=%0d exp=32", bit_count); end
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL acc_valid got=%b exp=1", word_valid); end
    checks++; if (word_data !== exp_word) begin failures++; $display("FAIL acc_word got=%h exp=%h", word_data, exp_word); end
    $display("test_accept word=%h", word_data);
  endtask

  task automatic test_reset_mid_word;
    logic [WORD_W-1:0] w;
    w = 32'hC3A596E1;
    do_clear();
    word_ready = 1'b0;
    send_word(words[1]);
    send_word(words[2]);
    for (int i = 0; i < 10; i++) tick_bit(i[0]);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL mid_level got=%0d exp=2", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", word_valid); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", fifo_level); end
    checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL mid_rst_bit_count got=%0d exp=0", bit_count); end
    checks++; if (word_data !== 32'd0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", word_data); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = WORD_W - 1; i >= 1; i--) tick_bit(w[i]);
    repeat (2) @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL mid_partial_valid got=%b exp=0", word_valid); end
    checks++; if (bit_count !== 32'd31) begin failures++; $display("FAIL mid_partial_count got=%0d exp=31", bit_count); end
    tick_bit(w[0]);
    @(negedge clk);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", word_valid); end
    checks++; if (word_data !== w) begin failures++; $display("FAIL mid_word got=%h exp=%h", word_data, w); end
    $display("test_reset_mid_word word=%h", word_data);
  endtask

  initial begin
    force dut.raw_bit = force_bit;
    test_reset();
`ifndef TRNG_VN_DEBIAS_EN
    test_continuous_word();
    test_trigger_and_divider();
    test_overflow();
    test_health();
`endif
    test_accept();
`ifndef TRNG_VN_DEBIAS_EN
    test_reset_mid_word();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
